// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional macro ALU_ARB_ILLEGAL_OP_EN adds rsp_err and zeroes data on bad opcodes.
module alu_arbiter_alu #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [OPW-1:0]  op_i,
    output logic [XLEN-1:0] y_o
);
    localparam logic [OPW-1:0] ADD_ALU = OPW'(0);
    localparam logic [OPW-1:0] SUB_ALU = OPW'(1);
    localparam logic [OPW-1:0] AND_ALU = OPW'(2);
    localparam logic [OPW-1:0] OR_ALU  = OPW'(3);
    localparam logic [OPW-1:0] SLL_ALU = OPW'(4);
    localparam logic [OPW-1:0] SRA_ALU = OPW'(5);

    always_comb begin
        y_o = 'x;
        case (op_i)
            ADD_ALU: y_o = a_i + b_i;
            SUB_ALU: y_o = a_i - b_i;
            AND_ALU: y_o = a_i & b_i;
            OR_ALU:  y_o = a_i | b_i;
            SLL_ALU: y_o = a_i << b_i[4:0];
            SRA_ALU: y_o = $signed(a_i) >>> b_i[4:0];
            default: y_o = 'x;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_rs1,
    input  logic [XLEN-1:0] req0_rs2,
    input  logic [OPW-1:0]  req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_rs1,
    input  logic [XLEN-1:0] req1_rs2,
    input  logic [OPW-1:0]  req1_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
`ifdef ALU_ARB_ILLEGAL_OP_EN
    output logic            rsp_err,
`endif
    output logic            rsp_id
);
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            id_q, id_d;
    logic            can_accept;
    logic            gnt0, gnt1;
    logic [XLEN-1:0] alu_a, alu_b, alu_y;
    logic [OPW-1:0]  alu_op;

    assign can_accept = (state_q == IDLE) | rsp_ready;

    // Each ready looks only at the other side's valid, never its ready.
    assign gnt0 = can_accept & req0_valid & (~req1_valid | last_q);
    assign gnt1 = can_accept & req1_valid & (~req0_valid | ~last_q);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        unique case (1'b1)
            gnt0: begin
                alu_a  = req0_rs1;
                alu_b  = req0_rs2;
                alu_op = req0_op;
            end
            gnt1: begin
                alu_a  = req1_rs1;
                alu_b  = req1_rs2;
                alu_op = req1_op;
            end
            default: ;
        endcase
    end

    alu_arbiter_alu #(
        .XLEN (XLEN),
        .OPW  (OPW)
    ) u_alu (
        .a_i  (alu_a),
        .b_i  (alu_b),
        .op_i (alu_op),
        .y_o  (alu_y)
    );

`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic err_q, err_d;
    logic op_legal;

    assign op_legal = (alu_op <= OPW'(5));
    assign rsp_err  = err_q;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        data_d  = data_q;
        id_d    = id_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        err_d   = err_q;
`endif
        if (gnt0 | gnt1) begin
            state_d = RESP;
            id_d    = gnt1;
            last_d  = gnt1;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            data_d  = op_legal ? alu_y : '0;
            err_d   = ~op_legal;
`else
            data_d  = alu_y;
`endif
        end else if (state_q == RESP && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            data_q  <= '0;
            id_q    <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            data_q  <= data_d;
            id_q    <= id_d;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            err_q   <= err_d;
`endif
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized checks of alu_arbiter against a behavioural model.
module tb_alu_arbiter;
    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] AND = 4'd2;
    localparam logic [3:0] OR  = 4'd3;
    localparam logic [3:0] SLL = 4'd4;
    localparam logic [3:0] SRA = 4'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_rs1, req0_rs2;
    logic [3:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_rs1, req1_rs2;
    logic [3:0]  req1_op;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic        rsp_err;
`endif

    int ncmp = 0;
    int nfail = 0;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_rs1   (req0_rs1),
        .req0_rs2   (req0_rs2),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_rs1   (req1_rs1),
        .req1_rs2   (req1_rs2),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
`ifdef ALU_ARB_ILLEGAL_OP_EN
        .rsp_err    (rsp_err),
`endif
        .rsp_id     (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v0, input logic [3:0] o0,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [3:0] o1,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input logic rr);
        req0_valid = v0; req0_op = o0; req0_rs1 = a0; req0_rs2 = b0;
        req1_valid = v1; req1_op = o1; req1_rs1 = a1; req1_rs2 = b1;
        rsp_ready  = rr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drv(0, ADD, 0, 0, 0, ADD, 0, 0, 0);
        @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint unsigned s;
        int sh;
        sh = int'(b % 32);
        case (op)
            ADD: begin s = longint'(a) + longint'(b); return s[31:0]; end
            SUB: begin s = longint'(a) + 64'h1_0000_0000 - longint'(b); return s[31:0]; end
            AND: return a & b;
            OR:  return a | b;
            SLL: return 32'(longint'(a) * (64'd1 << sh));
            SRA: begin
                s = {{32{a[31]}}, a};
                return 32'(s >> sh);
            end
            default: return 32'hx;
        endcase
    endfunction

    logic [3:0]  ops [6];
    logic        p_v  [2];
    logic [3:0]  p_op [2];
    logic [31:0] p_a  [2];
    logic [31:0] p_b  [2];
    logic        m_v;
    logic [31:0] m_d;
    int          m_id, m_last, exp_gnt;
    logic        rr;

    initial begin
        ops[0] = ADD; ops[1] = SUB; ops[2] = AND;
        ops[3] = OR;  ops[4] = SLL; ops[5] = SRA;
        rst_n = 1'b0;
        drv(0, ADD, 0, 0, 0, ADD, 0, 0, 0);
        do_reset();

        // single request, one-cycle latency
        drv(1, ADD, 5, 7, 0, ADD, 0, 0, 1);
        #1 chk("t1_rdy0", 32'(req0_ready), 32'd1);
        chk("t1_rdy1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        drv(0, ADD, 0, 0, 0, ADD, 0, 0, 1);
        chk("t1_valid", 32'(rsp_valid), 32'd1);
        chk("t1_data", rsp_data, 32'd12);
        chk("t1_id", 32'(rsp_id), 32'd0);
        @(negedge clk);
        chk("t1_drain", 32'(rsp_valid), 32'd0);

        // contention alternates, one result per cycle
        do_reset();
        drv(1, SUB, 10, 3, 1, SLL, 1, 32'h24, 1);
        for (int k = 0; k < 4; k++) begin
            #1 chk("t2_rdy0", 32'(req0_ready), 32'(k % 2 == 0));
            chk("t2_rdy1", 32'(req1_ready), 32'(k % 2 == 1));
            @(negedge clk);
            chk("t2_valid", 32'(rsp_valid), 32'd1);
            chk("t2_id", 32'(rsp_id), 32'(k % 2));
            chk("t2_data", rsp_data, (k % 2 == 0) ? 32'd7 : 32'h10);
        end
        drv(0, ADD, 0, 0, 0, ADD, 0, 0, 1);
        @(negedge clk);

        // response stall
        drv(0, ADD, 0, 0, 1, SRA, 32'h8000_0000, 4, 1);
        @(negedge clk);
        drv(1, ADD, 32'hFFFF_FFFF, 1, 0, ADD, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1 chk("t3_rdy0", 32'(req0_ready), 32'd0);
            chk("t3_rdy1", 32'(req1_ready), 32'd0);
            chk("t3_valid", 32'(rsp_valid), 32'd1);
            chk("t3_data", rsp_data, 32'hF800_0000);
            chk("t3_id", 32'(rsp_id), 32'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1 chk("t3_release", 32'(req0_ready), 32'd1);
        @(negedge clk);
        chk("t3_wrap_data", rsp_data, 32'd0);
        chk("t3_wrap_id", 32'(rsp_id), 32'd0);

        // reset while a response is held
        drv(0, ADD, 0, 0, 0, ADD, 0, 0, 0);
        @(negedge clk);
        chk("t4_held", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("t4_async", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drv(1, ADD, 2, 3, 1, SUB, 9, 1, 1);
        #1 chk("t4_first0", 32'(req0_ready), 32'd1);
        chk("t4_first1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        chk("t4_data", rsp_data, 32'd5);

        // shift amount uses only rs2[4:0]
        drv(1, SLL, 1, 32'h21, 0, ADD, 0, 0, 1);
        @(negedge clk);
        chk("t5_sll", rsp_data, 32'd2);
        chk("t5_id", 32'(rsp_id), 32'd0);
        drv(0, ADD, 0, 0, 0, ADD, 0, 0, 1);
        @(negedge clk);

`ifdef ALU_ARB_ILLEGAL_OP_EN
        drv(1, 4'hF, 32'h1234, 32'h5678, 0, ADD, 0, 0, 1);
        @(negedge clk);
        chk("t6_err", 32'(rsp_err), 32'd1);
        chk("t6_data", rsp_data, 32'd0);
        drv(1, AND, 32'hF0, 32'h3C, 0, ADD, 0, 0, 1);
        @(negedge clk);
        chk("t6_err_clr", 32'(rsp_err), 32'd0);
        chk("t6_and", rsp_data, 32'h30);
        drv(0, ADD, 0, 0, 0, ADD, 0, 0, 1);
        @(negedge clk);
`endif

        // randomized traffic against the reference model
        do_reset();
        m_v = 1'b0; m_d = '0; m_id = 0; m_last = 1;
        for (int r = 0; r < 2; r++) p_v[r] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!p_v[r]) begin
                    p_v[r]  = ($urandom_range(0, 99) < 60);
                    p_op[r] = ops[$urandom_range(0, 5)];
                    p_a[r]  = $urandom;
                    p_b[r]  = $urandom;
                end
            end
            rr = ($urandom_range(0, 99) < 70);
            drv(p_v[0], p_op[0], p_a[0], p_b[0],
                p_v[1], p_op[1], p_a[1], p_b[1], rr);
            exp_gnt = -1;
            if (!m_v || rr) begin
                if (p_v[0] && p_v[1]) exp_gnt = 1 - m_last;
                else if (p_v[0])      exp_gnt = 0;
                else if (p_v[1])      exp_gnt = 1;
            end
            #1 chk("rnd_rdy0", 32'(req0_ready), 32'(exp_gnt == 0));
            chk("rnd_rdy1", 32'(req1_ready), 32'(exp_gnt == 1));
            @(negedge clk);
            if (exp_gnt >= 0) begin
                m_v    = 1'b1;
                m_d    = ref_alu(p_op[exp_gnt], p_a[exp_gnt], p_b[exp_gnt]);
                m_id   = exp_gnt;
                m_last = exp_gnt;
                p_v[exp_gnt] = 1'b0;
            end else if (m_v && rr) begin
                m_v = 1'b0;
            end
            chk("rnd_valid", 32'(rsp_valid), 32'(m_v));
            if (m_v) begin
                chk("rnd_data", rsp_data, m_d);
                chk("rnd_id", 32'(rsp_id), 32'(m_id));
`ifdef ALU_ARB_ILLEGAL_OP_EN
                chk("rnd_err", 32'(rsp_err), 32'd0);
`endif
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
